// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - VC0/VC1 pop arbiter with VC1 starvation guard and class-bit routing
module vc_arbiter #(
  parameter int BW        = 6,
  parameter int MAX_BURST = 4,
  parameter int CW        = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          VC0_empty,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC0_data_out,
  input  logic [BW-1:0] VC1_data_out,
  input  logic          D0_almost_full,
  input  logic          D1_almost_full,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic [BW-1:0] data_out,
  output logic          D0_push,
  output logic          D1_push,
  output logic [1:0]    arb_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] burst_cnt;
  logic          inflight_vld;
  logic          inflight_vc;
  logic          stall;
  logic          any_ready;
  logic          grant0;
  logic          grant1;
  logic [BW-1:0] sel_word;

  // The word class is unknown until it is popped, so either destination filling up stalls reads.
  assign stall     = D0_almost_full | D1_almost_full;
  assign any_ready = !VC0_empty || !VC1_empty;
  assign sel_word  = inflight_vc ? VC1_data_out : VC0_data_out;
  assign VC0_rd    = grant0;
  assign VC1_rd    = grant1;
  assign arb_state = state;

  // Grant selection: VC0 wins unless it has used up its burst while VC1 waits.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && state == ACTIVE && !stall) begin
      if (!VC0_empty && (VC1_empty || burst_cnt < CW'(MAX_BURST))) begin
        grant0 = 1'b1;
      end else if (!VC1_empty) begin
        grant1 = 1'b1;
      end
    end
  end

  // Arbiter state machine; PAUSE only blocks new reads, in-flight words still drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (stall) state <= PAUSE;
          else if (any_ready) state <= ACTIVE;
        end
        ACTIVE: begin
          if (stall) state <= PAUSE;
          else if (!any_ready) state <= IDLE;
        end
        PAUSE: begin
          if (!stall) state <= any_ready ? ACTIVE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts VC0 grants taken while VC1 is waiting; saturates so VC1 is forced next.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (grant1 || VC1_empty) begin
      burst_cnt <= '0;
    end else if (grant0 && burst_cnt < CW'(MAX_BURST)) begin
      burst_cnt <= burst_cnt + CW'(1);
    end
  end

  // Two-stage datapath: remember which VC was popped, then latch its word and push by class bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_vld <= 1'b0;
      inflight_vc  <= 1'b0;
      data_out     <= '0;
      D0_push      <= 1'b0;
      D1_push      <= 1'b0;
    end else begin
      inflight_vld <= grant0 | grant1;
      inflight_vc  <= grant1;
      D0_push      <= inflight_vld & !sel_word[BW-1];
      D1_push      <= inflight_vld & sel_word[BW-1];
      if (inflight_vld) data_out <= sel_word;
    end
  end

endmodule
